// File: rtl/aes_subbytes_iter.sv
// aes_subbytes_iter: iterative AES SubBytes using LANES registered S-box lanes.
// Define AES_SUBBYTES_INV_EN to build the inverse S-box tables into each lane.
module aes_subbytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         kill,
  input  logic         en,
  input  logic         inv,
  input  logic [127:0] in_data,
  output logic         busy,
  output logic         done,
  output logic [127:0] out_data
);

  localparam int P  = 16 / LANES;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int GW = 8 * LANES;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [0:255][7:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef AES_SUBBYTES_INV_EN
  localparam logic [0:255][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
  logic inv_q;
`else
  logic inv_unused;
  assign inv_unused = inv;
`endif

  if (LANES != 1 && LANES != 2 && LANES != 4 &&
      LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  wgrp;
  logic           vld;
  logic [127:0]   in_q;
  logic [6:0]     rbase;
  logic [6:0]     wbase;
  logic [GW-1:0]  grp;
  logic [GW-1:0]  res;
  logic [7:0]     sbox_q [LANES];

  assign rbase = 7'(int'(cnt) * GW);
  assign wbase = 7'(int'(wgrp) * GW);
  assign grp   = in_q[rbase +: GW];
  assign busy  = (state != S_IDLE);

  // Table lanes carry no reset so they can map onto block RAM.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    always_ff @(posedge clk) begin
`ifdef AES_SUBBYTES_INV_EN
      sbox_q[l] <= inv_q ? INV[grp[8*l +: 8]] : FWD[grp[8*l +: 8]];
`else
      sbox_q[l] <= FWD[grp[8*l +: 8]];
`endif
    end
    assign res[8*l +: 8] = sbox_q[l];
  end

  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wgrp     <= '0;
      vld      <= 1'b0;
      done     <= 1'b0;
      in_q     <= '0;
      out_data <= '0;
`ifdef AES_SUBBYTES_INV_EN
      inv_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      vld  <= 1'b0;
      if (vld) out_data[wbase +: GW] <= res;
      unique case (state)
        S_IDLE: begin
          if (en) begin
            in_q  <= in_data;
`ifdef AES_SUBBYTES_INV_EN
            inv_q <= inv;
`endif
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          vld  <= 1'b1;
          wgrp <= cnt;
          if (cnt == CW'(P - 1)) state <= S_DRAIN;
          else cnt <= cnt + 1'b1;
        end
        S_DRAIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_subbytes_iter.sv
// tb_aes_subbytes_iter: directed checks of aes_subbytes_iter at LANES=4,1,2,8,16.
// Optional inverse checks follow AES_SUBBYTES_INV_EN.
module tb_aes_subbytes_iter;

  localparam int NI = 5;
  localparam int LN [NI] = '{4, 1, 2, 8, 16};

  logic         clk = 1'b0;
  logic         kill = 1'b0;
  logic         en = 1'b0;
  logic         inv = 1'b0;
  logic [127:0] in_data = '0;
  logic         busy_v [NI];
  logic         done_v [NI];
  logic [127:0] out_v  [NI];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_subbytes_iter #(.LANES(4)) u4 (
    .clk(clk), .kill(kill), .en(en), .inv(inv), .in_data(in_data),
    .busy(busy_v[0]), .done(done_v[0]), .out_data(out_v[0]));
  aes_subbytes_iter #(.LANES(1)) u1 (
    .clk(clk), .kill(kill), .en(en), .inv(inv), .in_data(in_data),
    .busy(busy_v[1]), .done(done_v[1]), .out_data(out_v[1]));
  aes_subbytes_iter #(.LANES(2)) u2 (
    .clk(clk), .kill(kill), .en(en), .inv(inv), .in_data(in_data),
    .busy(busy_v[2]), .done(done_v[2]), .out_data(out_v[2]));
  aes_subbytes_iter #(.LANES(8)) u8 (
    .clk(clk), .kill(kill), .en(en), .inv(inv), .in_data(in_data),
    .busy(busy_v[3]), .done(done_v[3]), .out_data(out_v[3]));
  aes_subbytes_iter #(.LANES(16)) u16 (
    .clk(clk), .kill(kill), .en(en), .inv(inv), .in_data(in_data),
    .busy(busy_v[4]), .done(done_v[4]), .out_data(out_v[4]));

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Reference S-box from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^
        {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] sb128(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb(d[8*i +: 8]);
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [127:0] d,
                        input logic iv, input logic [127:0] exp);
    int lat [NI];
    logic [127:0] res [NI];
    int bcnt = 0;
    int both = 0;
    for (int i = 0; i < NI; i++) begin lat[i] = 0; res[i] = '0; end
    @(negedge clk);
    in_data = d; inv = iv; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; in_data = ~d; inv = ~iv;
    if (busy_v[0]) bcnt++;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      in_data = {4{$urandom}};
      for (int i = 0; i < NI; i++)
        if (done_v[i] && lat[i] == 0) begin
          lat[i] = n; res[i] = out_v[i];
        end
      if (busy_v[0]) bcnt++;
      if (busy_v[0] && done_v[0]) both++;
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_lat_L%0d", tag, LN[i]), 128'(lat[i]), 128'(16 / LN[i] + 1));
      check($sformatf("%s_out_L%0d", tag, LN[i]), res[i], exp);
    end
    check({tag, "_busy_cycles"}, 128'(bcnt), 128'd5);
    check({tag, "_busy_and_done"}, 128'(both), 128'd0);
  endtask

  initial begin : main
    logic [127:0] hist [18];
    int dn;
    #20;
    check("rst_busy", 128'(busy_v[0]), 128'd0);
    check("rst_done", 128'(done_v[0]), 128'd0);
    check("rst_out", out_v[0], 128'h0);
    check("rst_out_L16", out_v[4], 128'h0);
    #30 kill = 1'b1;

    run_op("fwd", 128'hf0e0d0c0b0a090807060504030201000, 1'b0,
           128'h8ce170bae7e060cd51d0530904b7ca63);
    run_op("fwd_zero", 128'h0, 1'b0, {16{8'h63}});
`ifdef AES_SUBBYTES_INV_EN
    run_op("inv_rt", 128'h8ce170bae7e060cd51d0530904b7ca63, 1'b1,
           128'hf0e0d0c0b0a090807060504030201000);
    run_op("inv_zero", 128'h0, 1'b1, {16{8'h52}});
`else
    run_op("noinv_zero", 128'h0, 1'b1, {16{8'h63}});
`endif

    // en held high for three back-to-back operations on the LANES=4 unit.
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      hist[k] = {$urandom, $urandom, $urandom, $urandom};
      in_data = hist[k];
      inv = 1'b0;
      en = (k <= 12);
      @(posedge clk); #1;
      if (k == 5 || k == 11 || k == 17) begin
        check($sformatf("hs_done_e%0d", k), 128'(done_v[0]), 128'd1);
        check($sformatf("hs_out_e%0d", k), out_v[0], sb128(hist[k-5]));
      end else begin
        check($sformatf("hs_done_e%0d", k), 128'(done_v[0]), 128'd0);
      end
    end
    @(negedge clk);
    en = 1'b0;
    repeat (8) @(posedge clk);

    // Kill two cycles into an operation.
    @(negedge clk);
    in_data = 128'hf0e0d0c0b0a090807060504030201000; en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    repeat (2) @(posedge clk);
    #2 kill = 1'b0;
    #1;
    check("kill_busy", 128'(busy_v[0]), 128'd0);
    check("kill_done", 128'(done_v[0]), 128'd0);
    check("kill_out", out_v[0], 128'h0);
    #20 kill = 1'b1;
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_v[0]) dn++;
    end
    check("kill_no_done", 128'(dn), 128'd0);

    // en and kill together: kill wins.
    @(negedge clk);
    en = 1'b1; kill = 1'b0;
    @(posedge clk); #1;
    en = 1'b0; kill = 1'b1;
    @(posedge clk); #1;
    check("kill_en_busy", 128'(busy_v[0]), 128'd0);

    run_op("after_kill", 128'h00112233445566778899aabbccddeeff, 1'b0,
           128'h638293c31bfc33f5c4eeacea4bc12816);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
